// File: rtl/bram_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_share_arbiter
// Purpose  : Two-requester round-robin sharing of a 256x16 block RAM with
//            independent read/write arbitration and optional clear after reset.
// Revision : 1.0 - initial release
// ============================================================================
module bram_share_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        busy,
    input  logic        A_req,
    input  logic        A_we,
    input  logic [7:0]  A_addr,
    input  logic [15:0] A_wdata,
    output logic        A_ready,
    output logic        A_rvalid,
    input  logic        B_req,
    input  logic        B_we,
    input  logic [7:0]  B_addr,
    input  logic [15:0] B_wdata,
    output logic        B_ready,
    output logic        B_rvalid,
    output logic [15:0] rdata
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam state_t C_INIT_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_clr_cnt;
    logic        r_last_rd_b;
    logic        r_last_wr_b;
    logic        r_coll_pend;

    logic        r_re;
    logic        r_we;
    logic [7:0]  r_raddr;
    logic [7:0]  r_waddr;
    logic [15:0] r_wdata;
    logic        r_re_b;
    logic        r_rvalid_a;
    logic        r_rvalid_b;
    logic [15:0] r_rdata;
    logic [15:0] r_mem [0:255];

    logic        w_run;
    logic        w_clr_we;
    logic        w_rd_a;
    logic        w_rd_b;
    logic        w_wr_a;
    logic        w_wr_b;
    logic        w_rd_any;
    logic        w_wr_any;
    logic        w_rd_sel_b;
    logic        w_wr_sel_b;
    logic [7:0]  w_raddr;
    logic [7:0]  w_waddr;
    logic [15:0] w_wdata;
    logic        w_coll;
    logic        w_rd_go;
    logic        w_wr_go;

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state == S_CLEAR);
        w_clr_we     = (r_state == S_CLEAR);
        w_run        = (r_state == S_RUN) && !reset;

        if (r_state == S_CLEAR && r_clr_cnt == 8'hFF) begin
            w_next_state = S_RUN;
        end

        w_rd_a   = A_req && !A_we;
        w_rd_b   = B_req && !B_we;
        w_wr_a   = A_req && A_we;
        w_wr_b   = B_req && B_we;
        w_rd_any = w_rd_a || w_rd_b;
        w_wr_any = w_wr_a || w_wr_b;

        // On a tie the requester that did not win last time gets the port.
        w_rd_sel_b = w_rd_b && (!w_rd_a || !r_last_rd_b);
        w_wr_sel_b = w_wr_b && (!w_wr_a || !r_last_wr_b);

        w_raddr = w_rd_sel_b ? B_addr  : A_addr;
        w_waddr = w_wr_sel_b ? B_addr  : A_addr;
        w_wdata = w_wr_sel_b ? B_wdata : A_wdata;

        // Same-address read/write: write goes first, then the deferred read wins.
        w_coll  = w_rd_any && w_wr_any && (w_raddr == w_waddr);
        w_rd_go = w_run && w_rd_any && !(w_coll && !r_coll_pend);
        w_wr_go = w_run && w_wr_any && !(w_coll && r_coll_pend);

        A_ready = (w_rd_go && !w_rd_sel_b) || (w_wr_go && !w_wr_sel_b);
        B_ready = (w_rd_go && w_rd_sel_b)  || (w_wr_go && w_wr_sel_b);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= C_INIT_STATE;
            r_clr_cnt   <= 8'd0;
            r_last_rd_b <= 1'b1;
            r_last_wr_b <= 1'b1;
            r_coll_pend <= 1'b0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_raddr     <= 8'd0;
            r_waddr     <= 8'd0;
            r_wdata     <= 16'd0;
            r_re_b      <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_CLEAR && r_clr_cnt != 8'hFF) begin
                r_clr_cnt <= r_clr_cnt + 8'd1;
            end

            if (w_rd_go) begin
                r_last_rd_b <= w_rd_sel_b;
                r_coll_pend <= 1'b0;
            end else if (w_coll) begin
                r_coll_pend <= 1'b1;
            end
            if (w_wr_go) begin
                r_last_wr_b <= w_wr_sel_b;
            end

            r_re       <= w_rd_go;
            r_raddr    <= w_raddr;
            r_re_b     <= w_rd_sel_b;
            r_we       <= w_clr_we || w_wr_go;
            r_waddr    <= w_clr_we ? r_clr_cnt   : w_waddr;
            r_wdata    <= w_clr_we ? CLEAR_VALUE : w_wdata;
            r_rvalid_a <= r_re && !r_re_b;
            r_rvalid_b <= r_re && r_re_b;
        end
    end

    // Block RAM core: port registers above feed a synchronous-read array.
    always_ff @(posedge CLK) begin
        if (r_we) begin
            r_mem[r_waddr] <= r_wdata;
        end
        if (r_re) begin
            r_rdata <= r_mem[r_raddr];
        end
    end

    assign A_rvalid = r_rvalid_a;
    assign B_rvalid = r_rvalid_b;
    assign rdata    = r_rdata;

endmodule
`default_nettype wire
